alu_issue_stage: RTL and testbench

- Producer side of the ALU interface: decodes RV32I instruction fields into `alu_op`, selects and registers `alu_data_1`/`alu_data_2`.
- Presents them to the execute-stage ALU through a one-entry valid/ready pipeline register.
- Sits between decode/register-read and execute. Supports stall, flush, illegal-op tagging and a wrapping issue counter.

---
 rtl/alu_issue_stage_pkg.sv | 70 +++++++
 rtl/alu_issue_stage_if.sv | 48 ++++
 rtl/alu_issue_stage_decoder.sv | 90 +++++++++
 rtl/alu_issue_stage.sv | 104 ++++++++++
 tb/tb_alu_issue_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// ============================================================================
// alu_issue_stage_pkg : ALU opcode codes, RV32I opcodes, operand-select types
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_issue_stage_pkg;

   // Shared ALU opcode encoding
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      SRC1_ZERO = 2'd0,
      SRC1_RS1  = 2'd1,
      SRC1_PC   = 2'd2
   } src1_sel_e;

   typedef enum logic [1:0] {
      SRC2_ZERO = 2'd0,
      SRC2_RS2  = 2'd1,
      SRC2_IMM  = 2'd2,
      SRC2_FOUR = 2'd3
   } src2_sel_e;

   typedef struct packed {
      logic [3:0] op;
      src1_sel_e  src1;
      src2_sel_e  src2;
      logic       illegal;
   } dec_t;

   // funct3 -> ALU op for the register/immediate arithmetic groups
   function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_alu_op = ALU_ADD;
         3'b001:  base_alu_op = ALU_SLL;
         3'b010:  base_alu_op = ALU_SLT;
         3'b011:  base_alu_op = ALU_SLTU;
         3'b100:  base_alu_op = ALU_XOR;
         3'b101:  base_alu_op = ALU_SRL;
         3'b110:  base_alu_op = ALU_OR;
         default: base_alu_op = ALU_AND;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
// ============================================================================
// alu_issue_stage_if : upstream decode bundle plus ALU request bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_issue_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [4:0]       rd_idx;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  imm;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       alu_op;
   logic [XLEN-1:0]  alu_data_1;
   logic [XLEN-1:0]  alu_data_2;
   logic [4:0]       rd_out;
   logic             illegal;
   logic [CNT_W-1:0] issue_count;

   // master: the issue stage (ALU request producer)
   modport master (
      input  in_valid, opcode, funct3, funct7, rd_idx, pc, rs1_data, rs2_data,
             imm, flush, out_ready,
      output in_ready, out_valid, alu_op, alu_data_1, alu_data_2, rd_out,
             illegal, issue_count
   );

   // slave: the surrounding decode and execute logic
   modport slave (
      output in_valid, opcode, funct3, funct7, rd_idx, pc, rs1_data, rs2_data,
             imm, flush, out_ready,
      input  in_ready, out_valid, alu_op, alu_data_1, alu_data_2, rd_out,
             illegal, issue_count
   );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage_decoder.sv
// ============================================================================
// alu_op_decoder : RV32I opcode/funct3/funct7 -> ALU op, operand selects, illegal
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
   import alu_issue_stage_pkg::*;
(
   input  wire logic [6:0] opcode,
   input  wire logic [2:0] funct3,
   input  wire logic [6:0] funct7,
   output dec_t            dec
);

   logic [3:0] w_op;
   src1_sel_e  w_src1;
   src2_sel_e  w_src2;
   logic       w_illegal;

   always_comb begin
      w_op      = ALU_ADD;
      w_src1    = SRC1_ZERO;
      w_src2    = SRC2_ZERO;
      w_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            w_src1 = SRC1_RS1;
            w_src2 = SRC2_RS2;
            w_op   = base_alu_op(funct3);
            if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000)      w_op = ALU_SUB;
               else if (funct3 == 3'b101) w_op = ALU_SRA;
               else                       w_illegal = 1'b1;
            end else if (funct7 != F7_ZERO) begin
               w_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // funct7 field only has meaning for the shift-immediate forms
            w_src1 = SRC1_RS1;
            w_src2 = SRC2_IMM;
            w_op   = base_alu_op(funct3);
            if (funct3 == 3'b001 && funct7 != F7_ZERO) begin
               w_illegal = 1'b1;
            end else if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)       w_op = ALU_SRA;
               else if (funct7 != F7_ZERO) w_illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            w_src2 = SRC2_IMM;
         end
         OPC_AUIPC: begin
            w_src1 = SRC1_PC;
            w_src2 = SRC2_IMM;
         end
         OPC_LOAD, OPC_STORE: begin
            w_src1 = SRC1_RS1;
            w_src2 = SRC2_IMM;
         end
         OPC_BRANCH: begin
            w_src1 = SRC1_RS1;
            w_src2 = SRC2_RS2;
            case (funct3)
               3'b000, 3'b001: w_op = ALU_SUB;
               3'b100, 3'b101: w_op = ALU_SLT;
               3'b110, 3'b111: w_op = ALU_SLTU;
               default:        w_illegal = 1'b1;
            endcase
         end
         OPC_JAL, OPC_JALR: begin
            w_src1 = SRC1_PC;
            w_src2 = SRC2_FOUR;
         end
         default: w_illegal = 1'b1;
      endcase
      // Undecodable entries carry a neutral ADD 0,0 request
      if (w_illegal) begin
         w_op   = ALU_ADD;
         w_src1 = SRC1_ZERO;
         w_src2 = SRC2_ZERO;
      end
   end

   assign dec = '{op: w_op, src1: w_src1, src2: w_src2, illegal: w_illegal};

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : operand select + one-entry valid/ready register to the ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input wire logic          clk,
   input wire logic          rst_n,
   alu_issue_stage_if.master bus
);

   dec_t             w_dec;
   logic [XLEN-1:0]  w_data_1;
   logic [XLEN-1:0]  w_data_2;
   logic             w_in_ready;
   logic             w_load;

   logic             r_valid;
   logic [3:0]       r_op;
   logic [XLEN-1:0]  r_data_1;
   logic [XLEN-1:0]  r_data_2;
   logic [4:0]       r_rd;
   logic             r_illegal;
   logic [CNT_W-1:0] r_count;

   alu_op_decoder u_decoder (
      .opcode (bus.opcode),
      .funct3 (bus.funct3),
      .funct7 (bus.funct7),
      .dec    (w_dec)
   );

   always_comb begin
      w_data_1 = '0;
      case (w_dec.src1)
         SRC1_RS1: w_data_1 = bus.rs1_data;
         SRC1_PC:  w_data_1 = bus.pc;
         default:  w_data_1 = '0;
      endcase
   end

   always_comb begin
      w_data_2 = '0;
      case (w_dec.src2)
         SRC2_RS2:  w_data_2 = bus.rs2_data;
         SRC2_IMM:  w_data_2 = bus.imm;
         SRC2_FOUR: w_data_2 = XLEN'(4);
         default:   w_data_2 = '0;
      endcase
   end

   // Ready whenever the slot is empty or being drained this cycle
   assign w_in_ready = ~r_valid | bus.out_ready;
   assign w_load     = bus.in_valid & w_in_ready & ~bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_op      <= ALU_ADD;
         r_data_1  <= '0;
         r_data_2  <= '0;
         r_rd      <= '0;
         r_illegal <= 1'b0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid   <= 1'b1;
         r_op      <= w_dec.op;
         r_data_1  <= w_data_1;
         r_data_2  <= w_data_2;
         r_rd      <= bus.rd_idx;
         r_illegal <= w_dec.illegal;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // A consumed request still counts when a flush lands in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (r_valid && bus.out_ready) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_valid;
   assign bus.alu_op      = r_op;
   assign bus.alu_data_1  = r_data_1;
   assign bus.alu_data_2  = r_data_2;
   assign bus.rd_out      = r_rd;
   assign bus.illegal     = r_illegal;
   assign bus.issue_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage : directed + random stimulus against a cycle-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   localparam int CW = 8;   // narrow counter so the wrap is reachable

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.XLEN(32), .CNT_W(CW)) bus ();

   alu_issue_stage #(.XLEN(32), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        ill;
   } ref_t;

   logic          m_valid;
   logic [3:0]    m_op;
   logic [31:0]   m_d1, m_d2;
   logic [4:0]    m_rd;
   logic          m_ill;
   logic [CW-1:0] m_cnt;

   function automatic ref_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] pc,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm);
      logic [3:0] tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      ref_t r;
      r = '{op: ALU_ADD, d1: 32'd0, d2: 32'd0, ill: 1'b0};
      if (opc == OPC_OP) begin
         r.ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         r.op  = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : tbl[f3];
         r.d1 = rs1; r.d2 = rs2;
      end else if (opc == OPC_OP_IMM) begin
         r.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                 (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         r.op  = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
         r.d1 = rs1; r.d2 = imm;
      end else if (opc == OPC_LUI) begin
         r.d2 = imm;
      end else if (opc == OPC_AUIPC) begin
         r.d1 = pc; r.d2 = imm;
      end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
         r.d1 = rs1; r.d2 = imm;
      end else if (opc == OPC_BRANCH) begin
         r.ill = (f3 == 3'd2 || f3 == 3'd3);
         r.op  = (f3 < 3'd2) ? ALU_SUB : (f3 < 3'd6) ? ALU_SLT : ALU_SLTU;
         r.d1 = rs1; r.d2 = rs2;
      end else if (opc == OPC_JAL || opc == OPC_JALR) begin
         r.d1 = pc; r.d2 = 32'd4;
      end else begin
         r.ill = 1'b1;
      end
      if (r.ill) r = '{op: ALU_ADD, d1: 32'd0, d2: 32'd0, ill: 1'b1};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_op = ALU_ADD; m_d1 = '0; m_d2 = '0;
      m_rd = '0; m_ill = 1'b0; m_cnt = '0;
   endtask

   task automatic check_outputs();
      chk("out_valid",   32'(bus.out_valid),   32'(m_valid));
      chk("alu_op",      32'(bus.alu_op),      32'(m_op));
      chk("alu_data_1",  bus.alu_data_1,       m_d1);
      chk("alu_data_2",  bus.alu_data_2,       m_d2);
      chk("rd_out",      32'(bus.rd_out),      32'(m_rd));
      chk("illegal",     32'(bus.illegal),     32'(m_ill));
      chk("issue_count", 32'(bus.issue_count), 32'(m_cnt));
   endtask

   task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm);
      bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7; bus.rd_idx = rd;
      bus.pc = pc; bus.rs1_data = rs1; bus.rs2_data = rs2; bus.imm = imm;
   endtask

   task automatic ctl(input logic v, input logic r, input logic f);
      bus.in_valid = v; bus.out_ready = r; bus.flush = f;
   endtask

   // One clock: check in_ready, advance the model, check registered outputs
   task automatic cycle();
      ref_t r;
      logic take;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      take = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
      if (m_valid && bus.out_ready) m_cnt = m_cnt + 1'b1;
      if (bus.flush) begin
         m_valid = 1'b0;
      end else if (take) begin
         r = ref_decode(bus.opcode, bus.funct3, bus.funct7, bus.pc,
                        bus.rs1_data, bus.rs2_data, bus.imm);
         m_valid = 1'b1; m_op = r.op; m_d1 = r.d1; m_d2 = r.d2;
         m_ill = r.ill; m_rd = bus.rd_idx;
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] opcs [10] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                                OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, 7'h7F};
      logic [6:0] opc;
      logic [6:0] f7;

      rst_n = 1'b0;
      ctl(1'b0, 1'b0, 1'b0);
      set_instr(7'h0, 3'h0, 7'h0, 5'h0, '0, '0, '0, '0);
      model_reset();
      #12;
      check_outputs();
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back SUB then SRAI with the consumer always ready
      ctl(1'b1, 1'b1, 1'b0);
      set_instr(OPC_OP, 3'b000, 7'h20, 5'd3, 32'h0, 32'd5, 32'd7, 32'h0);
      cycle();
      chk("b2b_sub_op", 32'(bus.alu_op), 32'(ALU_SUB));
      chk("b2b_sub_d1", bus.alu_data_1, 32'd5);
      chk("b2b_sub_d2", bus.alu_data_2, 32'd7);
      set_instr(OPC_OP_IMM, 3'b101, 7'h20, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'd4);
      cycle();
      chk("b2b_sra_op", 32'(bus.alu_op), 32'(ALU_SRA));
      chk("b2b_sra_d1", bus.alu_data_1, 32'h8000_0000);
      chk("b2b_sra_d2", bus.alu_data_2, 32'd4);
      ctl(1'b0, 1'b1, 1'b0);
      cycle();
      chk("b2b_count", 32'(bus.issue_count), 32'd2);

      // Stall: hold an entry with the consumer blocked, then release
      ctl(1'b1, 1'b1, 1'b0);
      set_instr(OPC_OP, 3'b110, 7'h00, 5'd9, 32'h0, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0);
      cycle();
      ctl(1'b1, 1'b0, 1'b0);
      set_instr(OPC_OP, 3'b111, 7'h00, 5'd10, 32'h0, 32'h1234_5678, 32'h0000_FFFF, 32'h0);
      repeat (3) cycle();
      chk("stall_held_op", 32'(bus.alu_op), 32'(ALU_OR));
      ctl(1'b1, 1'b1, 1'b0);
      cycle();
      chk("stall_release_op", 32'(bus.alu_op), 32'(ALU_AND));
      ctl(1'b0, 1'b1, 1'b0);
      cycle();

      // Flush with the slot empty, then flush while a held entry is consumed
      ctl(1'b1, 1'b0, 1'b1);
      set_instr(OPC_OP, 3'b100, 7'h00, 5'd11, 32'h0, 32'd1, 32'd2, 32'h0);
      cycle();
      chk("flush_drop_valid", 32'(bus.out_valid), 32'd0);
      ctl(1'b1, 1'b0, 1'b0);
      cycle();
      ctl(1'b1, 1'b1, 1'b1);
      cycle();
      ctl(1'b0, 1'b0, 1'b0);
      cycle();

      // AUIPC, JAL, BGEU, then illegal forms
      ctl(1'b1, 1'b1, 1'b0);
      set_instr(OPC_AUIPC, 3'b000, 7'h00, 5'd1, 32'h1000, 32'hDEAD, 32'hBEEF, 32'h2000);
      cycle();
      chk("auipc_d1", bus.alu_data_1, 32'h1000);
      set_instr(OPC_JAL, 3'b000, 7'h00, 5'd1, 32'h40, 32'hDEAD, 32'hBEEF, 32'h800);
      cycle();
      chk("jal_d2", bus.alu_data_2, 32'd4);
      set_instr(OPC_BRANCH, 3'b111, 7'h00, 5'd0, 32'h40, 32'd17, 32'd18, 32'h10);
      cycle();
      chk("bgeu_op", 32'(bus.alu_op), 32'(ALU_SLTU));
      set_instr(7'h7F, 3'b000, 7'h00, 5'd2, 32'h40, 32'd17, 32'd18, 32'h10);
      cycle();
      chk("illegal_opc", 32'(bus.illegal), 32'd1);
      set_instr(OPC_OP, 3'b010, 7'h20, 5'd2, 32'h40, 32'd17, 32'd18, 32'h10);
      cycle();
      chk("illegal_funct", 32'(bus.illegal), 32'd1);
      ctl(1'b0, 1'b1, 1'b0);
      cycle();

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         opc = opcs[$urandom_range(0, 9)];
         if (opc == 7'h7F) opc = 7'($urandom_range(0, 127));
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         set_instr(opc, 3'($urandom), f7, 5'($urandom), $urandom, $urandom, $urandom, $urandom);
         ctl($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         cycle();
      end

      // Continuous flow long enough to wrap the counter
      ctl(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 270; i++) begin
         set_instr(OPC_LOAD, 3'b010, 7'h00, 5'($urandom), $urandom, $urandom, $urandom, $urandom);
         cycle();
      end

      // Async reset while an entry is held
      ctl(1'b1, 1'b0, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      ctl(1'b0, 1'b0, 1'b0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
